sd_spi_byte_engine: RTL and testbench
=====================================

Name: sd_spi_byte_engine

Overview:
SPI-mode-0 byte transceiver on the master side of the SD card link.
- Generates sclk from clk through a programmable half-period divider.
- Shifts one command/data byte out on mosi, MSB first, while shifting one byte in from miso.
- Sits between the SD command/data FSMs, which hand it bytes with a valid/ready handshake, and the card pins. It is the driving end for the sclk edge detection used on the card-facing side.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; must be ≥1. sclk period = 2*CLK_DIV clk cycles.
BYTE_W, 8, bits per transfer. Fixed at 8 for SD; not intended to be overridden.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous reset, active-low
tx_data  in  8  byte to transmit; captured on accept
tx_valid  in  1  tx_data valid
tx_ready  out  1  engine idle; byte accepted when tx_valid&&tx_ready
rx_data  out  8  byte received in the last completed transfer
rx_valid  out  1  one-cycle pulse when rx_data is updated
cs_en  in  1  request chip select asserted
sclk  out  1  SD serial clock, idle low
mosi  out  1  serial data to card, idle high
miso  in  1  serial data from card
cs_n  out  1  chip select to card, active-low

Behaviour:
- Reset values (asynchronous): sclk=0, mosi=1, cs_n=1, tx_ready=1, rx_valid=0, rx_data=8'h00, state IDLE, counters 0.
- FSM states:
  - IDLE: tx_ready=1.
  - LOW: sclk=0.
  - HIGH: sclk=1.
  - All outputs registered.
- Accept at cycle T (IDLE, tx_valid=1):
  - tx_data loads into the tx shift register; bit_cnt=0.
  - From T+1: state LOW, tx_ready=0, mosi=tx_data[7].
- LOW lasts CLK_DIV cycles, then HIGH (sclk rises at T+1+CLK_DIV).
- HIGH lasts CLK_DIV cycles.
  - In the final clk cycle of HIGH, miso shifts into the LSB of the rx shift register.
  - Next cycle sclk falls and mosi advances to the next bit.
- After the 8th HIGH phase: state IDLE at cycle T+1+16*CLK_DIV. In that same cycle:
  - rx_valid=1 for one cycle; rx_data=the received byte, MSB = first bit sampled.
  - tx_ready=1; mosi=1.
- Throughput: one byte per 16*CLK_DIV+1 cycles. A tx_valid held high during the IDLE cycle is accepted immediately.
- tx_valid while busy: ignored. tx_data is not re-sampled mid-byte.
- rx_data holds its value until the next completed transfer.
- cs_n = ~cs_en, registered, updated only while in IDLE. A change of cs_en during a byte takes effect on the cycle after return to IDLE. sclk never toggles across a cs_n edge.
- Reset asserted mid-byte: immediate return to reset values. No partial rx_valid is generated.
- Divider: the half-period counter runs 0..CLK_DIV-1 and wraps; it is cleared on accept. With CLK_DIV=1, sclk toggles every clk cycle.

Optional Feature:
Macro SD_SPI_INIT_CLK_EN.
- Defined:
  - Adds parameter INIT_DIV (default 64) and input port init_mode (1 bit).
  - Half-period = INIT_DIV when init_mode=1, else CLK_DIV. init_mode is latched at accept and held constant for the whole byte.
  - This supports the ≤400 kHz card identification phase.
- Undefined: port and parameter are absent; half-period is always CLK_DIV.

Decomposition:
- Package sd_spi_pkg:
  - state enum (IDLE, LOW, HIGH)
  - SD_BYTE_W=8
  - SD_IDLE_BYTE=8'hFF
  - bit-counter width constant
- Sub-module sd_spi_clk_div: half-period counter with clear input and a one-cycle phase_end tick. The FSM consumes phase_end to alternate LOW/HIGH.

Test Plan:
- Reset then idle 20 cycles -> sclk=0, mosi=1, cs_n=1, tx_ready=1, rx_valid=0, rx_data=8'h00.
- CLK_DIV=4, cs_en=1, send 8'hA5 with card model returning 8'h3C -> mosi bit sequence 1,0,1,0,0,1,0,1 sampled on sclk rising edges. sclk period 8 cycles. rx_valid pulses once at accept+65 with rx_data=8'h3C.
- Back-to-back: tx_valid held with 8'h40 then 8'hFF -> second accept occurs in the IDLE cycle where rx_valid pulses. Exactly 16 sclk rising edges, no glitch between bytes.
- tx_valid toggled and cs_en deasserted mid-byte -> transfer completes unchanged; cs_n rises the cycle after IDLE is reached; no extra accept.
- n_rst asserted after 3 sclk rises of a byte -> outputs immediately at reset values. No rx_valid pulse. Next byte after release transfers correctly.
- SD_SPI_INIT_CLK_EN defined, INIT_DIV=64, init_mode=1 for 8'hFF -> sclk period 128 cycles. init_mode flipped mid-byte has no effect. The following byte with init_mode=0 uses period 8.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD SPI byte engine: FSM state encoding,
// byte width, the idle bus byte and the bit-counter width.
package sd_spi_pkg;

  localparam int          SD_BYTE_W    = 8;
  localparam logic [7:0]  SD_IDLE_BYTE = 8'hFF;
  localparam int          SD_BIT_CNT_W = $clog2(SD_BYTE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } sd_spi_state_e;

endpackage

// File: rtl/sd_spi_clk_div.sv
// Half-period counter for the SPI clock: counts 0..i_half-1 while enabled and
// flags the last cycle of each phase with o_phase_end.
module sd_spi_clk_div #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_half,
  output logic         o_phase_end
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last      = (r_cnt == i_half - W'(1));
  assign o_phase_end = i_en && w_last;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_last) r_cnt <= '0;
      else        r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 master byte transceiver for the SD card link. Define
// SD_SPI_INIT_CLK_EN to add the slow identification clock (INIT_DIV, i_init_mode).
module sd_spi_byte_engine
  import sd_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int BYTE_W  = SD_BYTE_W
`ifdef SD_SPI_INIT_CLK_EN
  ,
  parameter int INIT_DIV = 64
`endif
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [BYTE_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_cs_en,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_cs_n,
`ifdef SD_SPI_INIT_CLK_EN
  input  logic              i_init_mode,
`endif
  output sd_spi_state_e     o_dbg_state
);

  // Handshake: a byte is taken on any clk edge where i_tx_valid && o_tx_ready;
  // o_rx_valid is a single-cycle strobe with no back-pressure.

`ifdef SD_SPI_INIT_CLK_EN
  localparam int MAX_DIV = (INIT_DIV > CLK_DIV) ? INIT_DIV : CLK_DIV;
`else
  localparam int MAX_DIV = CLK_DIV;
`endif
  localparam int DIV_W = $clog2(MAX_DIV + 1);

  sd_spi_state_e           r_state, w_state_nx;
  logic                    r_sclk, w_sclk_nx;
  logic                    r_mosi, w_mosi_nx;
  logic                    r_cs_n, w_cs_n_nx;
  logic                    r_tx_ready, w_tx_ready_nx;
  logic                    r_rx_valid, w_rx_valid_nx;
  logic [BYTE_W-1:0]       r_rx_data, w_rx_data_nx;
  logic [BYTE_W-2:0]       r_tx_sh, w_tx_sh_nx;
  logic [BYTE_W-2:0]       r_rx_sh, w_rx_sh_nx;
  logic [SD_BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nx;
  logic                    w_accept;
  logic                    w_phase_end;
  logic                    w_last_bit;
  logic [DIV_W-1:0]        w_half;

`ifdef SD_SPI_INIT_CLK_EN
  logic r_init_mode;

  // Divider choice is frozen for the whole byte so sclk never changes rate mid-transfer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        r_init_mode <= 1'b0;
    else if (w_accept) r_init_mode <= i_init_mode;
  end

  assign w_half = r_init_mode ? DIV_W'(INIT_DIV) : DIV_W'(CLK_DIV);
`else
  assign w_half = DIV_W'(CLK_DIV);
`endif

  sd_spi_clk_div #(.W(DIV_W)) u_clk_div (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_clear     (w_accept),
    .i_en        (r_state != IDLE),
    .i_half      (w_half),
    .o_phase_end (w_phase_end)
  );

  assign w_last_bit = (r_bit_cnt == SD_BIT_CNT_W'(BYTE_W - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b1;
      r_cs_n     <= 1'b1;
      r_tx_ready <= 1'b1;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_sclk     <= w_sclk_nx;
      r_mosi     <= w_mosi_nx;
      r_cs_n     <= w_cs_n_nx;
      r_tx_ready <= w_tx_ready_nx;
      r_rx_valid <= w_rx_valid_nx;
      r_rx_data  <= w_rx_data_nx;
      r_tx_sh    <= w_tx_sh_nx;
      r_rx_sh    <= w_rx_sh_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_sclk_nx     = r_sclk;
    w_mosi_nx     = r_mosi;
    w_cs_n_nx     = r_cs_n;
    w_tx_ready_nx = r_tx_ready;
    w_rx_valid_nx = 1'b0;
    w_rx_data_nx  = r_rx_data;
    w_tx_sh_nx    = r_tx_sh;
    w_rx_sh_nx    = r_rx_sh;
    w_bit_cnt_nx  = r_bit_cnt;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        // Chip select only moves here, so it can never change under a running sclk.
        w_cs_n_nx = ~i_cs_en;
        if (i_tx_valid) begin
          w_accept      = 1'b1;
          w_state_nx    = LOW;
          w_tx_ready_nx = 1'b0;
          w_sclk_nx     = 1'b0;
          w_mosi_nx     = i_tx_data[BYTE_W-1];
          w_tx_sh_nx    = i_tx_data[BYTE_W-2:0];
          w_bit_cnt_nx  = '0;
        end
      end
      LOW: begin
        if (w_phase_end) begin
          w_state_nx = HIGH;
          w_sclk_nx  = 1'b1;
        end
      end
      HIGH: begin
        if (w_phase_end) begin
          w_sclk_nx  = 1'b0;
          w_rx_sh_nx = {r_rx_sh[BYTE_W-3:0], i_miso};
          if (w_last_bit) begin
            w_state_nx    = IDLE;
            w_rx_valid_nx = 1'b1;
            w_rx_data_nx  = {r_rx_sh, i_miso};
            w_tx_ready_nx = 1'b1;
            w_mosi_nx     = SD_IDLE_BYTE[SD_BYTE_W-1];
          end else begin
            w_state_nx   = LOW;
            w_mosi_nx    = r_tx_sh[BYTE_W-2];
            w_tx_sh_nx   = {r_tx_sh[BYTE_W-3:0], SD_IDLE_BYTE[0]};
            w_bit_cnt_nx = r_bit_cnt + SD_BIT_CNT_W'(1);
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign o_tx_ready  = r_tx_ready;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_sclk      = r_sclk;
  assign o_mosi      = r_mosi;
  assign o_cs_n      = r_cs_n;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Self-checking bench for sd_spi_byte_engine: a card model on miso, a pin-level
// monitor, and per-scenario tasks comparing against timing derived from the divider.
module tb_sd_spi_byte_engine;
  import sd_spi_pkg::*;

  localparam int CLK_DIV = 4;
`ifdef SD_SPI_INIT_CLK_EN
  localparam int INIT_DIV = 64;
`endif

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          cs_en = 1'b0;
  logic          sclk;
  logic          mosi;
  logic          miso;
  logic          cs_n;
  sd_spi_state_e dbg_state;
`ifdef SD_SPI_INIT_CLK_EN
  logic          init_mode = 1'b0;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  sd_spi_byte_engine #(
    .CLK_DIV  (CLK_DIV)
`ifdef SD_SPI_INIT_CLK_EN
    ,
    .INIT_DIV (INIT_DIV)
`endif
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_tx_data   (tx_data),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (tx_ready),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .i_cs_en     (cs_en),
    .o_sclk      (sclk),
    .o_mosi      (mosi),
    .i_miso      (miso),
    .o_cs_n      (cs_n),
`ifdef SD_SPI_INIT_CLK_EN
    .i_init_mode (init_mode),
`endif
    .o_dbg_state (dbg_state)
  );

  // Card model: presents the current byte MSB first, advancing on sclk falls.
  logic [7:0] card_byte = 8'hFF;
  logic [7:0] card_q[$];
  logic [2:0] card_idx = 3'd0;
  assign miso = card_byte[3'd7 - card_idx];

  // Pin monitor and scoreboard queues.
  logic       prev_sclk = 1'b0;
  logic       prev_cs_n = 1'b1;
  logic [7:0] mon_sh = 8'h00;
  int         mon_bits = 0;
  logic [7:0] mosi_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         rx_cyc_q[$];
  int         cs_rise_cyc = -1;
  int         idle_prints = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_sclk = 1'b0;
      prev_cs_n = 1'b1;
      mon_bits  = 0;
      card_idx  = 3'd0;
    end else begin
      if (sclk && !prev_sclk) begin
        rise_q.push_back(cyc);
        mon_sh   = {mon_sh[6:0], mosi};
        mon_bits = mon_bits + 1;
        if (mon_bits == 8) begin
          mosi_q.push_back(mon_sh);
          mon_bits = 0;
        end
      end
      if (!sclk && prev_sclk) begin
        if (card_idx == 3'd7) begin
          if (card_q.size() > 0) card_byte = card_q.pop_front();
          else                   card_byte = 8'hFF;
        end
        card_idx = card_idx + 3'd1;
      end
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        rx_cyc_q.push_back(cyc);
      end
      if (cs_n && !prev_cs_n) cs_rise_cyc = cyc;
      if (tx_ready) begin
        n_assert = n_assert + 1;
        if (sclk !== 1'b0 || mosi !== 1'b1) begin
          n_fail = n_fail + 1;
          if (idle_prints < 5)
            $display("FAIL idle_pins cyc=%0d sclk=%b mosi=%b required sclk=0 mosi=1", cyc, sclk, mosi);
          idle_prints = idle_prints + 1;
        end
      end
      prev_sclk = sclk;
      prev_cs_n = cs_n;
    end
  end

  function automatic int exp_done_cyc(input int t_acc, input int half);
    return t_acc + 1 + 16 * half;
  endfunction

  task automatic clear_sb();
    mosi_q.delete();
    rx_q.delete();
    rise_q.delete();
    rx_cyc_q.delete();
    exp_q.delete();
  endtask

  // Presents a byte and returns the cycle in which it was accepted (-1 on timeout).
  task automatic drive_byte(input logic [7:0] d, output int t_acc);
    tx_data  = d;
    tx_valid = 1'b1;
    t_acc    = -1;
    for (int i = 0; i < 3000 && t_acc < 0; i++) begin
      if (tx_ready === 1'b1) t_acc = cyc;
      else @(negedge clk);
    end
    if (t_acc < 0) begin
      n_assert = n_assert + 1;
      n_fail   = n_fail + 1;
      $display("FAIL accept_timeout data=%h tx_ready never high", d);
    end
    @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rx_q.size() < n) begin
      n_assert = n_assert + 1;
      n_fail   = n_fail + 1;
      $display("FAIL rx_timeout got %0d rx pulses required %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; tx_valid = 1'b0; cs_en = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    n_assert++; if (sclk !== 1'b0)     begin n_fail++; $display("FAIL reset_sclk got %b required 0", sclk); end
    n_assert++; if (mosi !== 1'b1)     begin n_fail++; $display("FAIL reset_mosi got %b required 1", mosi); end
    n_assert++; if (cs_n !== 1'b1)     begin n_fail++; $display("FAIL reset_cs_n got %b required 1", cs_n); end
    n_assert++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b required 1", tx_ready); end
    n_assert++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b required 0", rx_valid); end
    n_assert++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h required 00", rx_data); end
    n_assert++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d required IDLE", dbg_state); end
  endtask

  // One full byte at a given half-period; checks pins, data and timing.
  task automatic run_byte(input string tag, input logic [7:0] d, input logic [7:0] c, input int half);
    int t;
    clear_sb();
    card_byte = c;
    exp_q.push_back(c);
    drive_byte(d, t);
    tx_valid = 1'b0;
    wait_rx(1, 16 * half + 40);
    repeat (4) @(negedge clk);
    n_assert++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL %s rx_count got %0d required 1", tag, rx_q.size()); end
    if (rx_q.size() == 1) begin
      n_assert++; if (rx_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL %s rx_data got %h required %h", tag, rx_q[0], exp_q[0]); end
      n_assert++; if (rx_cyc_q[0] != exp_done_cyc(t, half)) begin n_fail++; $display("FAIL %s rx_cycle got %0d required %0d", tag, rx_cyc_q[0], exp_done_cyc(t, half)); end
    end
    n_assert++; if (mosi_q.size() != 1 || mosi_q[0] !== d) begin n_fail++; $display("FAIL %s mosi_bits got %h (n=%0d) required %h", tag, (mosi_q.size() > 0) ? mosi_q[0] : 8'h00, mosi_q.size(), d); end
    n_assert++; if (rise_q.size() != 8) begin n_fail++; $display("FAIL %s sclk_rises got %0d required 8", tag, rise_q.size()); end
    if (rise_q.size() == 8) begin
      n_assert++; if (rise_q[0] != t + 1 + half) begin n_fail++; $display("FAIL %s first_rise got %0d required %0d", tag, rise_q[0], t + 1 + half); end
      for (int i = 1; i < 8; i++) begin
        n_assert++;
        if (rise_q[i] - rise_q[i-1] != 2 * half) begin
          n_fail++; $display("FAIL %s sclk_period[%0d] got %0d required %0d", tag, i, rise_q[i] - rise_q[i-1], 2 * half);
        end
      end
    end
  endtask

  task automatic test_single();
    cs_en = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++; if (cs_n !== 1'b0) begin n_fail++; $display("FAIL cs_assert got %b required 0", cs_n); end
    run_byte("single", 8'hA5, 8'h3C, CLK_DIV);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_byte("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), CLK_DIV);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    logic [7:0] c1, c2;
    clear_sb();
    c1 = 8'($urandom_range(0, 255));
    c2 = 8'($urandom_range(0, 255));
    card_byte = c1;
    card_q.delete();
    card_q.push_back(c2);
    drive_byte(8'h40, t1);
    drive_byte(8'hFF, t2);
    tx_valid = 1'b0;
    wait_rx(2, 40 * CLK_DIV + 40);
    repeat (4) @(negedge clk);
    n_assert++; if (t2 != exp_done_cyc(t1, CLK_DIV)) begin n_fail++; $display("FAIL b2b_second_accept got %0d required %0d", t2, exp_done_cyc(t1, CLK_DIV)); end
    n_assert++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL b2b_rx_count got %0d required 2", rx_q.size()); end
    if (rx_q.size() == 2) begin
      n_assert++; if (rx_cyc_q[0] != t2) begin n_fail++; $display("FAIL b2b_rx0_cycle got %0d required %0d", rx_cyc_q[0], t2); end
      n_assert++; if (rx_cyc_q[1] != exp_done_cyc(t2, CLK_DIV)) begin n_fail++; $display("FAIL b2b_rx1_cycle got %0d required %0d", rx_cyc_q[1], exp_done_cyc(t2, CLK_DIV)); end
      n_assert++; if (rx_q[0] !== c1 || rx_q[1] !== c2) begin n_fail++; $display("FAIL b2b_rx_data got %h %h required %h %h", rx_q[0], rx_q[1], c1, c2); end
    end
    n_assert++; if (mosi_q.size() != 2) begin n_fail++; $display("FAIL b2b_mosi_count got %0d required 2", mosi_q.size()); end
    if (mosi_q.size() == 2) begin
      n_assert++; if (mosi_q[0] !== 8'h40 || mosi_q[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_mosi got %h %h required 40 FF", mosi_q[0], mosi_q[1]); end
    end
    n_assert++; if (rise_q.size() != 16) begin n_fail++; $display("FAIL b2b_rises got %0d required 16", rise_q.size()); end
    if (rise_q.size() == 16) begin
      for (int i = 1; i < 16; i++) begin
        n_assert++;
        if (rise_q[i] - rise_q[i-1] != ((i == 8) ? 2 * CLK_DIV + 1 : 2 * CLK_DIV)) begin
          n_fail++; $display("FAIL b2b_spacing[%0d] got %0d required %0d", i, rise_q[i] - rise_q[i-1], (i == 8) ? 2 * CLK_DIV + 1 : 2 * CLK_DIV);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int t;
    logic [7:0] d, c;
    clear_sb();
    d = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(1, 255));
    card_byte   = c;
    cs_rise_cyc = -1;
    drive_byte(d, t);
    for (int i = 0; i < 30; i++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom_range(0, 255));
      if (i == 10) cs_en = 1'b0;
      if (i == 20) begin
        n_assert++; if (cs_n !== 1'b0) begin n_fail++; $display("FAIL busy_cs_held got %b required 0", cs_n); end
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_rx(1, 16 * CLK_DIV + 40);
    repeat (60) @(negedge clk);
    n_assert++; if (mosi_q.size() != 1 || mosi_q[0] !== d) begin n_fail++; $display("FAIL busy_mosi got %h (n=%0d) required %h", (mosi_q.size() > 0) ? mosi_q[0] : 8'h00, mosi_q.size(), d); end
    n_assert++; if (rx_q.size() != 1 || rx_q[0] !== c) begin n_fail++; $display("FAIL busy_rx got %h (n=%0d) required %h", (rx_q.size() > 0) ? rx_q[0] : 8'h00, rx_q.size(), c); end
    n_assert++; if (rise_q.size() != 8) begin n_fail++; $display("FAIL busy_extra_accept rises got %0d required 8", rise_q.size()); end
    if (rx_cyc_q.size() == 1) begin
      n_assert++; if (cs_rise_cyc != rx_cyc_q[0] + 1) begin n_fail++; $display("FAIL busy_cs_rise got %0d required %0d", cs_rise_cyc, rx_cyc_q[0] + 1); end
    end
    n_assert++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL busy_tx_ready got %b required 1", tx_ready); end
    cs_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t, k;
    clear_sb();
    card_byte = 8'($urandom_range(0, 255));
    drive_byte(8'($urandom_range(0, 255)), t);
    tx_valid = 1'b0;
    k = 0;
    while (rise_q.size() < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_assert++; if (rise_q.size() != 3) begin n_fail++; $display("FAIL midrst_rises got %0d required 3", rise_q.size()); end
    n_rst = 1'b0;
    #1;
    n_assert++; if (sclk !== 1'b0)     begin n_fail++; $display("FAIL midrst_sclk got %b required 0", sclk); end
    n_assert++; if (mosi !== 1'b1)     begin n_fail++; $display("FAIL midrst_mosi got %b required 1", mosi); end
    n_assert++; if (cs_n !== 1'b1)     begin n_fail++; $display("FAIL midrst_cs_n got %b required 1", cs_n); end
    n_assert++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_ready got %b required 1", tx_ready); end
    n_assert++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data got %h required 00", rx_data); end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (16 * CLK_DIV + 10) @(negedge clk);
    n_assert++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL midrst_rx_pulse got %0d pulses required 0", rx_q.size()); end
    run_byte("after_rst", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), CLK_DIV);
  endtask

`ifdef SD_SPI_INIT_CLK_EN
  task automatic test_init_clk();
    int t;
    clear_sb();
    card_byte = 8'($urandom_range(0, 255));
    exp_q.push_back(card_byte);
    init_mode = 1'b1;
    drive_byte(8'hFF, t);
    tx_valid = 1'b0;
    repeat (100) @(negedge clk);
    init_mode = 1'b0;
    wait_rx(1, 16 * INIT_DIV + 40);
    repeat (4) @(negedge clk);
    n_assert++; if (rx_cyc_q.size() != 1 || rx_cyc_q[0] != exp_done_cyc(t, INIT_DIV)) begin n_fail++; $display("FAIL init_rx_cycle got %0d required %0d", (rx_cyc_q.size() > 0) ? rx_cyc_q[0] : -1, exp_done_cyc(t, INIT_DIV)); end
    n_assert++; if (rx_q.size() != 1 || rx_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL init_rx_data got %h required %h", (rx_q.size() > 0) ? rx_q[0] : 8'h00, exp_q[0]); end
    n_assert++; if (rise_q.size() != 8) begin n_fail++; $display("FAIL init_rises got %0d required 8", rise_q.size()); end
    if (rise_q.size() == 8) begin
      for (int i = 1; i < 8; i++) begin
        n_assert++;
        if (rise_q[i] - rise_q[i-1] != 2 * INIT_DIV) begin
          n_fail++; $display("FAIL init_period[%0d] got %0d required %0d", i, rise_q[i] - rise_q[i-1], 2 * INIT_DIV);
        end
      end
    end
    run_byte("post_init", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), CLK_DIV);
  endtask
`endif

  initial begin
    #900000;
    n_fail = n_fail + 1;
    $display("FAIL watchdog simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
`ifdef SD_SPI_INIT_CLK_EN
    test_init_clk();
`endif
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
